// File: rtl/spi_op_router.sv
// spi_op_router: parses SPI opcode frames into words and queues them in per-channel show-ahead FIFOs.
// Optional feature: SPI_ROUTER_EXT_KBD_EN merges a local keyboard source into channel 0 behind SPI.
module spi_op_router #(
   parameter int NUM_CH        = 3,
   parameter int PAYLOAD_BYTES = 3,
   parameter int DATA_W        = 8 * PAYLOAD_BYTES,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     frame_active,
   input  logic [7:0]               rx_byte,
   input  logic                     rx_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH-1:0]        ch_ready,
   output logic                     frame_err,
   output logic [NUM_CH-1:0]        overflow
`ifdef SPI_ROUTER_EXT_KBD_EN
   ,
   input  logic [DATA_W-1:0]        ext_kbd_data,
   input  logic                     ext_kbd_valid,
   output logic                     ext_kbd_ready
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(PAYLOAD_BYTES + 1);
   typedef enum logic [1:0] {S_OP, S_PAY, S_DISCARD} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0] ch_sel, ch_sel_n, cch, cch_n;
   logic [DATA_W-1:0] asm_r, asm_n, cword, cword_n, ext_data;
   logic cvld, cvld_n, err_n, ext_push;
   logic [NUM_CH-1:0] spi_req, has_space, ovf_n;
   // frame parser: opcode check, big-endian payload assembly, commit arming
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ch_sel_n = ch_sel;
      asm_n    = asm_r;
      cword_n  = cword;
      cch_n    = cch;
      cvld_n   = 1'b0;
      err_n    = 1'b0;
      if (!frame_active) begin
         state_n = S_OP;
         cnt_n   = '0;
         err_n   = (state == S_PAY) && (cnt != '0);
      end else if (rx_valid) begin
         case (state)
            S_OP: begin
               if (rx_byte >= 8'd1 && rx_byte <= 8'(NUM_CH)) begin
                  ch_sel_n = rx_byte - 8'd1;
                  cnt_n    = '0;
                  state_n  = S_PAY;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_DISCARD;
               end
            end
            S_PAY: begin
               asm_n = (asm_r << 8) | DATA_W'(rx_byte);
               cnt_n = cnt + 1'b1;
               if (cnt == CW'(PAYLOAD_BYTES - 1)) begin
                  cvld_n  = 1'b1;
                  cword_n = asm_n;
                  cch_n   = ch_sel;
                  cnt_n   = '0;
                  state_n = S_OP;
               end
            end
            default: ;
         endcase
      end
   end
   // parser state, armed commit and registered error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_OP;
         cnt       <= '0;
         ch_sel    <= '0;
         asm_r     <= '0;
         cword     <= '0;
         cch       <= '0;
         cvld      <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ch_sel    <= ch_sel_n;
         asm_r     <= asm_n;
         cword     <= cword_n;
         cch       <= cch_n;
         cvld      <= cvld_n;
         frame_err <= err_n;
         overflow  <= ovf_n;
      end
   end
`ifdef SPI_ROUTER_EXT_KBD_EN
   logic alive;
   // holds ext_kbd_ready low while in reset and for the first cycle after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive <= 1'b0;
      else        alive <= 1'b1;
   end
   assign ext_kbd_ready = alive && has_space[0] && !spi_req[0];
   assign ext_push      = ext_kbd_valid && ext_kbd_ready;
   assign ext_data      = ext_kbd_data;
`else
   assign ext_push = 1'b0;
   assign ext_data = '0;
`endif
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [AW-1:0] wp, rp;
      logic [AW:0] n;
      logic pop, push;
      assign pop          = ch_valid[c] && ch_ready[c];
      assign spi_req[c]   = cvld && (cch == 8'(c));
      assign has_space[c] = (n != (AW+1)'(DEPTH)) || pop;
      assign push         = (spi_req[c] || (c == 0 && ext_push)) && has_space[c];
      assign ovf_n[c]     = spi_req[c] && !has_space[c];
      assign ch_valid[c]  = n != '0;
      assign ch_data[c*DATA_W +: DATA_W] = ch_valid[c] ? mem[rp] : '0;
      // FIFO pointers and occupancy; a full FIFO accepts a push only alongside a pop
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            n  <= '0;
         end else begin
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            n  <= n + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
      // storage write; SPI commit wins over the external keyboard source
      always_ff @(posedge clk) begin
         if (push) mem[wp] <= spi_req[c] ? cword : ext_data;
      end
   end
endmodule

// File: tb/tb_spi_op_router.sv
// tb_spi_op_router: directed table-driven and sequence checks for spi_op_router.
module tb_spi_op_router;
   logic clk = 1'b0, rst_n = 1'b0, frame_active = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_byte = '0;
   logic [71:0] ch_data;
   logic [2:0] ch_valid, ch_ready = '0, overflow;
   logic frame_err;
   int total = 0, bad = 0, err_cnt = 0;
   int ovf_cnt [3] = '{0, 0, 0};

   always #5 clk = ~clk;

   spi_op_router dut (
      .clk(clk), .rst_n(rst_n), .frame_active(frame_active), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
      .frame_err(frame_err), .overflow(overflow)
`ifdef SPI_ROUTER_EXT_KBD_EN
      , .ext_kbd_data(24'h0), .ext_kbd_valid(1'b0), .ext_kbd_ready()
`endif
   );

   always @(negedge clk) begin
      err_cnt <= err_cnt + int'(frame_err);
      for (int i = 0; i < 3; i++) ovf_cnt[i] <= ovf_cnt[i] + int'(overflow[i]);
   end

   typedef struct {
      logic [7:0] op;
      logic [23:0] pay;
      int ch;
      logic err;
   } vec_t;
   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] op, input logic [23:0] p);
      send(op);
      send(p[23:16]);
      send(p[15:8]);
      send(p[7:0]);
   endtask

   task automatic pop(input logic [2:0] m);
      ch_ready = m;
      tick();
      ch_ready = '0;
   endtask

   task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [23:0] head(input int c);
      return ch_data[c*24 +: 24];
   endfunction

   int e0, o0;
   logic [23:0] w [5];

   initial begin
      vecs[0] = '{8'h01, 24'h123456, 0, 1'b0};
      vecs[1] = '{8'h02, 24'hA5A5A5, 1, 1'b0};
      vecs[2] = '{8'h03, 24'hFFFFFF, 2, 1'b0};
      vecs[3] = '{8'h03, 24'h000001, 2, 1'b0};
      vecs[4] = '{8'h00, 24'h010101, 0, 1'b1};
      vecs[5] = '{8'h04, 24'h112233, 0, 1'b1};
      vecs[6] = '{8'hFF, 24'h010203, 0, 1'b1};

      repeat (3) tick();
      chk("reset_valid", 72'(ch_valid), 72'h0);
      chk("reset_data", ch_data, 72'h0);
      chk("reset_err", 72'(frame_err), 72'h0);
      chk("reset_ovf", 72'(overflow), 72'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         e0 = err_cnt;
         frame_active = 1'b1;
         frame(vecs[i].op, vecs[i].pay);
         frame_active = 1'b0;
         tick();
         tick();
         chk($sformatf("vec%0d_err", i), 72'(err_cnt - e0), 72'(vecs[i].err));
         chk($sformatf("vec%0d_valid", i), 72'(ch_valid), vecs[i].err ? 72'h0 : 72'(3'b1 << vecs[i].ch));
         if (!vecs[i].err) chk($sformatf("vec%0d_data", i), 72'(head(vecs[i].ch)), 72'(vecs[i].pay));
         pop(3'b111);
         chk($sformatf("vec%0d_empty", i), {69'h0, ch_valid}, 72'h0);
      end

      frame_active = 1'b1;
      frame(8'h01, 24'hAABBCC);
      chk("b2b_lat0", 72'(ch_valid[0]), 72'h0);
      send(8'h02);
      chk("b2b_lat1", 72'(ch_valid[0]), 72'h1);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      chk("b2b_lat2", 72'(ch_valid[1]), 72'h0);
      tick();
      chk("b2b_valid", 72'(ch_valid), 72'h3);
      chk("b2b_ch0", 72'(head(0)), 72'hAABBCC);
      chk("b2b_ch1", 72'(head(1)), 72'h112233);
      frame_active = 1'b0;
      pop(3'b011);
      chk("b2b_empty_data", ch_data, 72'h0);

      e0 = err_cnt;
      frame_active = 1'b1;
      frame(8'h07, 24'h123456);
      frame_active = 1'b0;
      tick();
      frame_active = 1'b1;
      frame(8'h03, 24'h010203);
      tick();
      chk("badop_err", 72'(err_cnt - e0), 72'h1);
      chk("badop_valid", 72'(ch_valid), 72'h4);
      chk("badop_data", 72'(head(2)), 72'h010203);
      frame_active = 1'b0;
      pop(3'b100);

      e0 = err_cnt;
      frame_active = 1'b1;
      send(8'h01);
      send(8'hAA);
      frame_active = 1'b0;
      tick();
      tick();
      chk("short_err", 72'(err_cnt - e0), 72'h1);
      chk("short_nowrite", 72'(ch_valid), 72'h0);
      frame_active = 1'b1;
      send(8'h01);
      frame_active = 1'b0;
      tick();
      tick();
      chk("oponly_silent", 72'(err_cnt - e0), 72'h1);
      frame_active = 1'b1;
      frame(8'h01, 24'hDEADBE);
      frame_active = 1'b0;
      tick();
      chk("short_next", 72'(head(0)), 72'hDEADBE);
      pop(3'b001);

      frame(8'h01, 24'h999999);
      tick();
      chk("inactive_ignored", 72'(ch_valid), 72'h0);

      o0 = ovf_cnt[1];
      frame_active = 1'b1;
      for (int i = 0; i < 5; i++) begin
         w[i] = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};
         frame(8'h02, w[i]);
      end
      frame_active = 1'b0;
      tick();
      tick();
      chk("ovf_pulse", 72'(ovf_cnt[1] - o0), 72'h1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_pop%0d", i), 72'(head(1)), 72'(w[i]));
         pop(3'b010);
      end
      chk("ovf_drained", 72'(ch_valid), 72'h0);

      o0 = ovf_cnt[1];
      frame_active = 1'b1;
      for (int i = 0; i < 4; i++) frame(8'h02, w[i]);
      w[4] = 24'hC0FFEE;
      send(8'h02);
      send(8'hC0);
      send(8'hFF);
      send(8'hEE);
      chk("fullpp_head", 72'(head(1)), 72'(w[0]));
      pop(3'b010);
      frame_active = 1'b0;
      tick();
      chk("fullpp_noovf", 72'(ovf_cnt[1] - o0), 72'h0);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("fullpp_pop%0d", i), 72'(head(1)), 72'(w[i]));
         pop(3'b010);
      end
      chk("fullpp_drained", 72'(ch_valid), 72'h0);

      frame_active = 1'b1;
      frame(8'h02, 24'h445566);
      send(8'h01);
      send(8'h77);
      rst_n = 1'b0;
      #2;
      chk("rst_clear_valid", 72'(ch_valid), 72'h0);
      tick();
      rst_n = 1'b1;
      tick();
      frame(8'h01, 24'h556677);
      tick();
      chk("rst_resync", 72'(head(0)), 72'h556677);
      frame_active = 1'b0;
      pop(3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
